radial_zone_filter_fp16: RTL and testbench
==========================================

# radial_zone_filter_fp16

Parametrised, pipelined radial confidence/depth gate for the DFD depth stream. For each pixel it computes squared distance from a programmable optical centre. It selects the innermost annular zone containing the pixel and rejects the pixel if its fp16 confidence is below that zone's threshold or its fp16 depth exceeds the zone's depth limit. It sits between the depth/confidence estimator and the output packer, adds valid/ready backpressure, double-buffered zone tables and optional per-zone rejection statistics.

## Interface
- NO_ZONES, 4, number of zones (1..16)
- R2_W, 18, width of squared-radius values
- REJECT_MODE, 0, 0 = replace data with 16'h7FFF; 1 = pass data, force confidence to 16'h0000
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- data_i, confidence_i  in  16 each  fp16 depth and confidence
- col_i, row_i  in  16 each  unsigned pixel coordinates
- valid_i  in  1  input beat valid
- ready_o  out  1  input beat accepted when valid_i && ready_o
- col_center_i, row_center_i  in  16 each  optical centre; sampled per beat
- cfg_we_i  in  1  write shadow zone entry
- cfg_addr_i  in  $clog2(NO_ZONES)  shadow entry index
- cfg_c_i, cfg_z_i  in  16 each  confidence threshold, depth limit
- cfg_r2_i  in  R2_W  zone outer squared radius (exclusive)
- cfg_commit_i  in  1  request shadow→active copy
- cfg_pending_o  out  1  commit requested, not yet applied
- data_o, confidence_o, col_o, row_o  out  16 each  filtered beat
- zone_o  out  $clog2(NO_ZONES+1)  matched zone, NO_ZONES if none
- reject_o  out  1  beat was rejected
- valid_o  out  1  output beat valid
- ready_i  in  1  downstream ready

## Operation
- Stage 1: register beat; dc = col − col_center, dr = row − row_center as signed 17-bit.
- Stage 2: d2 = dc² + dr² as a 35-bit unsigned value; saturate to all-ones R2_W when the value exceeds R2_W bits. Truncation is not permitted.
- Stage 3: select the lowest index z with d2 < r2[z] (priority; no OR across zones). Reject if confidence < c[z] or data > z[z] or data[15] = 1. Compare as unsigned 16-bit; inputs are non-negative fp16. With no match, pass the beat with zone_o = NO_ZONES and reject_o = 0.
- Reject output per REJECT_MODE. col/row/other field pass unchanged.
- Zone tables: shadow and active, each NO_ZONES entries. cfg_we_i writes shadow only. cfg_addr_i ≥ NO_ZONES is ignored.
- Commit: cfg_commit_i sets pending. Pending is applied on the first accepted beat with col_i = 0 and row_i = 0 (start of frame) before that beat is evaluated. Pending is also applied in any cycle with no beat in the pipeline and no beat being accepted. Applying the commit clears pending.
- cfg_commit_i together with cfg_we_i: the write lands first, so the committed table includes it.
- Zone entries flow with each beat. A beat is evaluated with the active table captured at its acceptance, so a commit never splits a beat.

## Timing
- Latency 3 cycles, accept to valid_o, with ready_i held high. Throughput 1 beat/cycle.
- Global stall: stall = valid_o && !ready_i. ready_o = !stall, a combinational path from ready_i.
- While stalled, all stage registers and outputs hold.
- Reset: all valids 0, valid_o 0, cfg_pending_o 0, active and shadow tables 0, data/confidence/col/row/zone_o/reject_o outputs 0.
- Because the reset table has r2 = 0, no zone ever matches after reset.
- Reset mid-stream drops in-flight beats; no partial output.

## Configuration
- RADIAL_ZONE_STATS_EN defined: adds ports stats_clr_i (1), stats_addr_i ($clog2(NO_ZONES+1)) and stats_cnt_o (32).
  - Per-zone 32-bit saturating rejection counters, plus a total at address NO_ZONES.
  - A counter increments on an output handshake with reject_o = 1.
  - stats_cnt_o is registered, 1-cycle read latency.
  - stats_clr_i clears all counters. If clear coincides with an increment, the clear wins.
  - Counters reset to 0.
- Not defined: none of these ports or counters exist.

## Structure
- Package radial_zone_pkg:
  - zone_cfg_t struct {c, z, r2}.
  - FP16_REJECT = 16'h7FFF.
  - Function sat_r2 for the saturation rule.
- Sub-module radial_dist_sq: stages 1–2 with stall enable.
- Top level: zone tables, commit logic, stage 3, statistics.

## Test plan
- NO_ZONES = 2, center (100,100), zone0 {c = 0x3800, z = 0x4400, r2 = 100}:
  - pixel (105,100), conf 0x3400 → zone_o = 0, reject_o = 1, data_o = 0x7FFF after 3 cycles.
- Same pixel with conf 0x3C00 and data 0x4200 → passes unchanged, reject_o = 0.
- Pixel (1000,1000) with center (0,0), R2_W = 18 → d2 saturates to 0x3FFFF, no zone match. Zone r2 = 0x3FFFF does not match either (strict <).
- Drive ready_i low for 5 cycles mid-stream of 10 beats → no beat lost or duplicated, outputs stable while stalled, order preserved.
- Commit asserted mid-frame (row 3):
  - cfg_pending_o stays 1 until the beat at (0,0) is accepted.
  - That beat uses the new thresholds; earlier beats use the old ones.
- Async reset asserted with 3 beats in flight → valid_o falls immediately, no output after release; with stats, total counter reads 0.

Source files
------------

// File: rtl/radial_zone_pkg.sv
// Shared types and helpers for the radial zone filter.
package radial_zone_pkg;

  // Replacement depth for rejected beats when data is not passed through.
  localparam logic [15:0] FP16_REJECT = 16'h7FFF;

  // One zone entry: confidence threshold, depth limit, outer squared radius.
  // r2 is held at a fixed 32-bit width; the top zero-extends its R2_W input.
  typedef struct packed {
    logic [15:0] c;
    logic [15:0] z;
    logic [31:0] r2;
  } zone_cfg_t;

  // Clamp a squared distance to the all-ones value of a w-bit field (w <= 32).
  // The result is never truncated, so a large distance cannot wrap into a zone.
  function automatic logic [34:0] sat_r2(input logic [34:0] d2, input int unsigned w);
    logic [34:0] lim;
    lim = (35'd1 << w) - 35'd1;
    if (d2 > lim) return lim;
    return d2;
  endfunction

endpackage

// File: rtl/radial_dist_sq.sv
// Stages 1-2 of the radial zone filter: centre offsets, then saturated squared
// distance. Both stages advance only when en is high.
module radial_dist_sq
  import radial_zone_pkg::*;
#(
  parameter int unsigned R2_W = 18
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic [15:0] in_conf,
  input  logic [15:0] in_col,
  input  logic [15:0] in_row,
  input  logic [15:0] col_center,
  input  logic [15:0] row_center,
  output logic        s1_valid,
  output logic        s2_valid,
  output logic [34:0] s2_d2,
  output logic [15:0] s2_data,
  output logic [15:0] s2_conf,
  output logic [15:0] s2_col,
  output logic [15:0] s2_row
);

  logic        [15:0] s1_data, s1_conf, s1_col, s1_row;
  logic signed [16:0] s1_dc, s1_dr;
  logic signed [34:0] dc_ext, dr_ext, sq_sum;

  // Stage 1: register the beat and its signed offsets from the optical centre.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_conf  <= '0;
      s1_col   <= '0;
      s1_row   <= '0;
      s1_dc    <= '0;
      s1_dr    <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_data  <= in_data;
      s1_conf  <= in_conf;
      s1_col   <= in_col;
      s1_row   <= in_row;
      s1_dc    <= $signed({1'b0, in_col}) - $signed({1'b0, col_center});
      s1_dr    <= $signed({1'b0, in_row}) - $signed({1'b0, row_center});
    end
  end

  // Sum of squares; the true value is below 2^34 so 35 signed bits cannot overflow.
  always_comb begin
    dc_ext = $signed({{18{s1_dc[16]}}, s1_dc});
    dr_ext = $signed({{18{s1_dr[16]}}, s1_dr});
    sq_sum = dc_ext * dc_ext + dr_ext * dr_ext;
  end

  // Stage 2: register the saturated squared distance alongside the beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid <= 1'b0;
      s2_d2    <= '0;
      s2_data  <= '0;
      s2_conf  <= '0;
      s2_col   <= '0;
      s2_row   <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_d2    <= sat_r2($unsigned(sq_sum), R2_W);
      s2_data  <= s1_data;
      s2_conf  <= s1_conf;
      s2_col   <= s1_col;
      s2_row   <= s1_row;
    end
  end

endmodule

// File: rtl/radial_zone_filter_fp16.sv
// Radial confidence/depth gate: picks the innermost annular zone containing a
// pixel and rejects it on low confidence, excessive depth or a negative depth.
// Optional per-zone rejection statistics are built when RADIAL_ZONE_STATS_EN is
// defined.
module radial_zone_filter_fp16
  import radial_zone_pkg::*;
#(
  parameter int unsigned NO_ZONES    = 4,
  parameter int unsigned R2_W        = 18,
  parameter int unsigned REJECT_MODE = 0,
  localparam int unsigned AW = (NO_ZONES > 1) ? $clog2(NO_ZONES) : 1,
  localparam int unsigned ZW = $clog2(NO_ZONES + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [15:0]     data_i,
  input  logic [15:0]     confidence_i,
  input  logic [15:0]     col_i,
  input  logic [15:0]     row_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [15:0]     col_center_i,
  input  logic [15:0]     row_center_i,
  input  logic            cfg_we_i,
  input  logic [AW-1:0]   cfg_addr_i,
  input  logic [15:0]     cfg_c_i,
  input  logic [15:0]     cfg_z_i,
  input  logic [R2_W-1:0] cfg_r2_i,
  input  logic            cfg_commit_i,
  output logic            cfg_pending_o,
  output logic [15:0]     data_o,
  output logic [15:0]     confidence_o,
  output logic [15:0]     col_o,
  output logic [15:0]     row_o,
  output logic [ZW-1:0]   zone_o,
  output logic            reject_o,
`ifdef RADIAL_ZONE_STATS_EN
  input  logic            stats_clr_i,
  input  logic [ZW-1:0]   stats_addr_i,
  output logic [31:0]     stats_cnt_o,
`endif
  output logic            valid_o,
  input  logic            ready_i
);

  logic        stall, en, accept, sof, idle, apply;
  logic        s1_valid, s2_valid;
  logic [34:0] s2_d2;
  logic [15:0] s2_data, s2_conf, s2_col, s2_row;
  zone_cfg_t   wr_entry;
  zone_cfg_t   shadow [NO_ZONES];
  zone_cfg_t   active [NO_ZONES];
  zone_cfg_t   tbl1   [NO_ZONES];
  zone_cfg_t   tbl2   [NO_ZONES];

  // Global stall: a held output freezes every stage.
  always_comb begin
    stall   = valid_o && !ready_i;
    en      = !stall;
    ready_o = !stall;
    accept  = valid_i && !stall;
    sof     = accept && (col_i == 16'd0) && (row_i == 16'd0);
    idle    = !s1_valid && !s2_valid && !valid_o && !accept;
    // Only an already-registered request applies, so a same-cycle write is in shadow.
    apply   = cfg_pending_o && (sof || idle);
    wr_entry = '{c: cfg_c_i, z: cfg_z_i, r2: 32'(cfg_r2_i)};
  end

  // Shadow table: written by the config port only; out-of-range writes dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow <= '{default: '0};
    end else if (cfg_we_i && (32'(cfg_addr_i) < NO_ZONES)) begin
      shadow[cfg_addr_i] <= wr_entry;
    end
  end

  // Active table and commit request; a commit arriving as one applies stays pending.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active        <= '{default: '0};
      cfg_pending_o <= 1'b0;
    end else begin
      if (apply) active <= shadow;
      cfg_pending_o <= (cfg_pending_o && !apply) || cfg_commit_i;
    end
  end

  // Table snapshot travels with the beat; a start-of-frame commit is seen by that beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tbl1 <= '{default: '0};
      tbl2 <= '{default: '0};
    end else if (en) begin
      tbl1 <= apply ? shadow : active;
      tbl2 <= tbl1;
    end
  end

  radial_dist_sq #(
    .R2_W (R2_W)
  ) u_dist (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en         (en),
    .in_valid   (accept),
    .in_data    (data_i),
    .in_conf    (confidence_i),
    .in_col     (col_i),
    .in_row     (row_i),
    .col_center (col_center_i),
    .row_center (row_center_i),
    .s1_valid   (s1_valid),
    .s2_valid   (s2_valid),
    .s2_d2      (s2_d2),
    .s2_data    (s2_data),
    .s2_conf    (s2_conf),
    .s2_col     (s2_col),
    .s2_row     (s2_row)
  );

  logic          hit, rej;
  logic [ZW-1:0] zone_sel;
  zone_cfg_t     sel;
  logic [15:0]   out_data, out_conf;

  // Stage 3: lowest-index zone wins, then threshold tests against that zone only.
  always_comb begin
    hit      = 1'b0;
    zone_sel = ZW'(NO_ZONES);
    sel      = '0;
    for (int i = 0; i < int'(NO_ZONES); i++) begin
      if (!hit && (s2_d2 < {3'b000, tbl2[i].r2})) begin
        hit      = 1'b1;
        zone_sel = ZW'(i);
        sel      = tbl2[i];
      end
    end
    rej      = hit && ((s2_conf < sel.c) || (s2_data > sel.z) || s2_data[15]);
    out_data = s2_data;
    out_conf = s2_conf;
    if (rej) begin
      if (REJECT_MODE == 0) out_data = FP16_REJECT;
      else                  out_conf = 16'h0000;
    end
  end

  // Output register; holds while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o      <= 1'b0;
      data_o       <= '0;
      confidence_o <= '0;
      col_o        <= '0;
      row_o        <= '0;
      zone_o       <= '0;
      reject_o     <= 1'b0;
    end else if (en) begin
      valid_o      <= s2_valid;
      data_o       <= out_data;
      confidence_o <= out_conf;
      col_o        <= s2_col;
      row_o        <= s2_row;
      zone_o       <= zone_sel;
      reject_o     <= rej;
    end
  end

`ifdef RADIAL_ZONE_STATS_EN
  logic [31:0] cnt [NO_ZONES + 1];
  logic        cnt_inc;

  always_comb cnt_inc = valid_o && ready_i && reject_o;

  // Saturating rejection counters per zone plus a total; clear beats increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt         <= '{default: '0};
      stats_cnt_o <= '0;
    end else begin
      if (stats_clr_i) begin
        cnt <= '{default: '0};
      end else if (cnt_inc) begin
        if (cnt[zone_o] != '1) cnt[zone_o] <= cnt[zone_o] + 32'd1;
        if (cnt[NO_ZONES] != '1) cnt[NO_ZONES] <= cnt[NO_ZONES] + 32'd1;
      end
      stats_cnt_o <= (32'(stats_addr_i) <= NO_ZONES) ? cnt[stats_addr_i] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_radial_zone_filter_fp16.sv
// Directed bench for radial_zone_filter_fp16 (NO_ZONES = 2, R2_W = 18, REJECT_MODE = 0).
module tb_radial_zone_filter_fp16;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [15:0] data_i, confidence_i, col_i, row_i, col_center_i, row_center_i;
  logic        valid_i, ready_o, cfg_we_i, cfg_commit_i, cfg_pending_o;
  logic [0:0]  cfg_addr_i;
  logic [15:0] cfg_c_i, cfg_z_i;
  logic [17:0] cfg_r2_i;
  logic [15:0] data_o, confidence_o, col_o, row_o;
  logic [1:0]  zone_o;
  logic        reject_o, valid_o, ready_i;

  always #5 clk_i = ~clk_i;

  radial_zone_filter_fp16 #(
    .NO_ZONES    (2),
    .R2_W        (18),
    .REJECT_MODE (0)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .data_i        (data_i),
    .confidence_i  (confidence_i),
    .col_i         (col_i),
    .row_i         (row_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .col_center_i  (col_center_i),
    .row_center_i  (row_center_i),
    .cfg_we_i      (cfg_we_i),
    .cfg_addr_i    (cfg_addr_i),
    .cfg_c_i       (cfg_c_i),
    .cfg_z_i       (cfg_z_i),
    .cfg_r2_i      (cfg_r2_i),
    .cfg_commit_i  (cfg_commit_i),
    .cfg_pending_o (cfg_pending_o),
    .data_o        (data_o),
    .confidence_o  (confidence_o),
    .col_o         (col_o),
    .row_o         (row_o),
    .zone_o        (zone_o),
    .reject_o      (reject_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i)
  );

  int nvec  = 0;
  int nfail = 0;

  // Beat stimulus and hand-computed expected outputs.
  logic [15:0] b_col [16], b_row [16], b_cc [16], b_rc [16], b_data [16], b_conf [16];
  logic [15:0] e_data [16], e_conf [16];
  logic [1:0]  e_zone [16];
  logic        e_rej  [16];
  // Shadow write issued together with the commit inside a stream.
  logic [0:0]  cm_addr;
  logic [15:0] cm_c, cm_z;
  logic [17:0] cm_r2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_beat(input int i, input logic [15:0] col, input logic [15:0] row,
                          input logic [15:0] cc, input logic [15:0] rc,
                          input logic [15:0] data, input logic [15:0] conf,
                          input logic [15:0] edata, input logic [15:0] econf,
                          input logic [1:0] ezone, input logic erej);
    b_col[i] = col;  b_row[i] = row;  b_cc[i] = cc;  b_rc[i] = rc;
    b_data[i] = data; b_conf[i] = conf;
    e_data[i] = edata; e_conf[i] = econf; e_zone[i] = ezone; e_rej[i] = erej;
  endtask

  task automatic cfg_write(input logic [0:0] a, input logic [15:0] c, input logic [15:0] z,
                           input logic [17:0] r2, input logic commit);
    @(negedge clk_i);
    cfg_we_i = 1'b1; cfg_addr_i = a; cfg_c_i = c; cfg_z_i = z; cfg_r2_i = r2;
    cfg_commit_i = commit;
    @(negedge clk_i);
    cfg_we_i = 1'b0; cfg_commit_i = 1'b0;
  endtask

  // One step per clock: set ready, check outputs, offer the next beat.
  task automatic run_stream(input int n, input int stall_at, input int stall_len,
                            input int commit_at, input int pend_until);
    int sent, got, step, acc0;
    sent = 0; got = 0; step = 0; acc0 = 0;
    while (got < n && step < 200) begin
      @(negedge clk_i);
      ready_i = !(step >= stall_at && step < stall_at + stall_len);
      cfg_we_i = 1'b0; cfg_commit_i = 1'b0; valid_i = 1'b0;
      #1;
      if (commit_at >= 0 && sent > commit_at)
        chk("pending", 32'(cfg_pending_o), (sent <= pend_until) ? 32'd1 : 32'd0);
      if (valid_o && ready_i) begin
        if (got == 0) chk("latency", 32'(step - acc0), 32'd3);
        chk("data",   32'(data_o),       32'(e_data[got]));
        chk("conf",   32'(confidence_o), 32'(e_conf[got]));
        chk("col",    32'(col_o),        32'(b_col[got]));
        chk("row",    32'(row_o),        32'(b_row[got]));
        chk("zone",   32'(zone_o),       32'(e_zone[got]));
        chk("reject", 32'(reject_o),     32'(e_rej[got]));
        got++;
      end else if (valid_o) begin
        chk("stall_data", 32'(data_o), 32'(e_data[got]));
        chk("stall_col",  32'(col_o),  32'(b_col[got]));
      end
      if (sent < n) begin
        col_i = b_col[sent]; row_i = b_row[sent];
        col_center_i = b_cc[sent]; row_center_i = b_rc[sent];
        data_i = b_data[sent]; confidence_i = b_conf[sent];
        valid_i = 1'b1;
        if (sent == commit_at) begin
          cfg_we_i = 1'b1; cfg_addr_i = cm_addr; cfg_c_i = cm_c; cfg_z_i = cm_z;
          cfg_r2_i = cm_r2; cfg_commit_i = 1'b1;
        end
        if (ready_o) begin
          if (sent == 0) acc0 = step;
          sent++;
        end
      end
      step++;
    end
    chk("stream_done", 32'(got), 32'(n));
    @(negedge clk_i);
    valid_i = 1'b0; ready_i = 1'b1; cfg_we_i = 1'b0; cfg_commit_i = 1'b0;
  endtask

  logic seen;

  initial begin
    rst_ni = 1'b0;
    data_i = '0; confidence_i = '0; col_i = '0; row_i = '0;
    col_center_i = '0; row_center_i = '0; valid_i = 1'b0; ready_i = 1'b1;
    cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_c_i = '0; cfg_z_i = '0; cfg_r2_i = '0;
    cfg_commit_i = 1'b0;
    cm_addr = '0; cm_c = '0; cm_z = '0; cm_r2 = '0;
    #2;
    chk("rst_valid",   32'(valid_o),       32'd0);
    chk("rst_pending", 32'(cfg_pending_o), 32'd0);
    chk("rst_data",    32'(data_o),        32'd0);
    chk("rst_zone",    32'(zone_o),        32'd0);
    chk("rst_reject",  32'(reject_o),      32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Zone0 {3800,4400,100}, zone1 {0,FFFF,10000}; idle pipeline applies the commit.
    cfg_write(1'b0, 16'h3800, 16'h4400, 18'd100, 1'b0);
    cfg_write(1'b1, 16'h0000, 16'hFFFF, 18'd10000, 1'b1);
    chk("commit_pending", 32'(cfg_pending_o), 32'd1);
    @(negedge clk_i);
    chk("commit_idle_apply", 32'(cfg_pending_o), 32'd0);

    // Zone selection and rejection rules, centre (100,100).
    set_beat(0, 105, 100, 100, 100, 16'h4000, 16'h3400, 16'h7FFF, 16'h3400, 2'd0, 1'b1);
    set_beat(1, 105, 100, 100, 100, 16'h4200, 16'h3C00, 16'h4200, 16'h3C00, 2'd0, 1'b0);
    set_beat(2,  95, 100, 100, 100, 16'h4500, 16'h3C00, 16'h7FFF, 16'h3C00, 2'd0, 1'b1);
    set_beat(3, 109, 100, 100, 100, 16'h4400, 16'h3800, 16'h4400, 16'h3800, 2'd0, 1'b0);
    set_beat(4, 110, 100, 100, 100, 16'h4000, 16'h3400, 16'h4000, 16'h3400, 2'd1, 1'b0);
    set_beat(5, 150, 100, 100, 100, 16'h8001, 16'h3C00, 16'h7FFF, 16'h3C00, 2'd1, 1'b1);
    set_beat(6, 100, 300, 100, 100, 16'h4000, 16'h0000, 16'h4000, 16'h0000, 2'd2, 1'b0);
    run_stream(7, 1000, 0, -1, 0);

    // Zone1 r2 = all-ones: saturated distance must not match, a truncated one would.
    cfg_write(1'b1, 16'h0000, 16'hFFFF, 18'h3FFFF, 1'b1);
    @(negedge clk_i);
    chk("commit2_applied", 32'(cfg_pending_o), 32'd0);
    set_beat(0, 1000, 1000, 0, 0, 16'h4000, 16'h3C00, 16'h4000, 16'h3C00, 2'd2, 1'b0);
    set_beat(1, 300, 100, 100, 100, 16'h4000, 16'h3C00, 16'h4000, 16'h3C00, 2'd1, 1'b0);
    run_stream(2, 1000, 0, -1, 0);

    // Ten beats with ready_i low for five cycles mid-stream.
    for (int i = 0; i < 10; i++)
      set_beat(i, 16'(200 + i), 100, 100, 100, 16'(16'h1000 + i), 16'h2000,
               16'(16'h1000 + i), 16'h2000, 2'd1, 1'b0);
    run_stream(10, 5, 5, -1, 0);

    // Commit mid-frame lowering zone0 threshold to 0x3000; applies at beat (0,0).
    cm_addr = 1'b0; cm_c = 16'h3000; cm_z = 16'h4400; cm_r2 = 18'd100;
    set_beat(0, 105, 3, 100, 3, 16'h4000, 16'h3400, 16'h7FFF, 16'h3400, 2'd0, 1'b1);
    set_beat(1, 106, 3, 100, 3, 16'h4000, 16'h3400, 16'h7FFF, 16'h3400, 2'd0, 1'b1);
    set_beat(2, 107, 3, 100, 3, 16'h4000, 16'h3400, 16'h7FFF, 16'h3400, 2'd0, 1'b1);
    set_beat(3,   0, 0,   0, 0, 16'h4000, 16'h3400, 16'h4000, 16'h3400, 2'd0, 1'b0);
    set_beat(4, 105, 3, 100, 3, 16'h4000, 16'h3400, 16'h4000, 16'h3400, 2'd0, 1'b0);
    run_stream(5, 1000, 0, 0, 3);

    // Async reset with three beats in flight.
    for (int s = 0; s < 3; s++) begin
      @(negedge clk_i);
      col_i = 16'(105 + s); row_i = 100; col_center_i = 100; row_center_i = 100;
      data_i = 16'h4000; confidence_i = 16'h3400; valid_i = 1'b1;
    end
    @(negedge clk_i);
    valid_i = 1'b0;
    #1;
    chk("pre_reset_valid", 32'(valid_o), 32'd1);
    #1 rst_ni = 1'b0;
    #1;
    chk("async_valid",   32'(valid_o),  32'd0);
    chk("async_data",    32'(data_o),   32'd0);
    chk("async_reject",  32'(reject_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk_i);
      if (valid_o) seen = 1'b1;
    end
    chk("no_output_after_reset", 32'(seen), 32'd0);

    // Reset tables hold r2 = 0, so nothing matches.
    set_beat(0, 105, 100, 100, 100, 16'h4000, 16'h3400, 16'h4000, 16'h3400, 2'd2, 1'b0);
    run_stream(1, 1000, 0, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
